// File: rtl/ahb_slave_if_if.sv
// AHB-lite slave port plus downstream request/ack channel, grouped as one bundle.
// The slave modport is the bridge side; master covers the AHB master and the peripheral.
interface ahb_slave_if_if;
    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned SEL_W  = 3;
    localparam int unsigned CNT_W  = 8;

    // AHB side
    logic              Hwrite;
    logic              Hreadyin;
    logic [1:0]        Htrans;
    logic [ADDR_W-1:0] Haddr;
    logic [DATA_W-1:0] Hwdata;
    logic              Hreadyout;
    logic [1:0]        Hresp;
    logic [DATA_W-1:0] Hrdata;

    // downstream request side
    logic              req_valid;
    logic              req_write;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic [SEL_W-1:0]  req_sel;
    logic              req_ack;
    logic [DATA_W-1:0] ack_rdata;
    logic [CNT_W-1:0]  err_cnt;

    modport slave (
        input  Hwrite, Hreadyin, Htrans, Haddr, Hwdata, req_ack, ack_rdata,
        output Hreadyout, Hresp, Hrdata, req_valid, req_write, req_addr,
               req_wdata, req_sel, err_cnt
    );

    modport master (
        output Hwrite, Hreadyin, Htrans, Haddr, Hwdata, req_ack, ack_rdata,
        input  Hreadyout, Hresp, Hrdata, req_valid, req_write, req_addr,
               req_wdata, req_sel, err_cnt
    );
endinterface

// File: rtl/ahb_slave_if.sv
// AHB-lite slave bridge: decodes three 64 MB windows, forwards each transfer as a
// single downstream request and answers unmapped addresses with a two-cycle ERROR.
module ahb_slave_if (
    input  logic          Hclk,
    input  logic          Hresetn,
    ahb_slave_if_if.slave bus
);
    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned SEL_W  = 3;
    localparam int unsigned CNT_W  = 8;

    localparam logic [1:0]       RESP_OKAY  = 2'b00;
    localparam logic [1:0]       RESP_ERROR = 2'b01;
    localparam logic [CNT_W-1:0] CNT_MAX    = '1;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_CAPT = 3'd1,
        ST_REQ  = 3'd2,
        ST_RESP = 3'd3,
        ST_ERR1 = 3'd4,
        ST_ERR2 = 3'd5
    } state_t;

    state_t            state;
    state_t            state_nxt;

    logic              hready_q;
    logic              hready_nxt;
    logic [1:0]        hresp_q;
    logic [1:0]        hresp_nxt;
    logic              valid_q;
    logic              valid_nxt;

    logic [ADDR_W-1:0] addr_q;
    logic              write_q;
    logic [SEL_W-1:0]  sel_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] hrdata_q;
    logic [CNT_W-1:0]  err_q;

    logic [SEL_W-1:0]  sel_c;
    logic              mapped_c;
    logic              accept_c;
    logic              unused_trans;

    // Htrans[0] only separates NONSEQ from SEQ, which the bridge treats alike.
    assign unused_trans = bus.Htrans[0];

    // Windows are 64 MB aligned, so the top six address bits select the peripheral.
    always_comb begin
        sel_c = '0;
        case (bus.Haddr[ADDR_W-1:ADDR_W-6])
            6'h20:   sel_c = 3'b001;
            6'h21:   sel_c = 3'b010;
            6'h22:   sel_c = 3'b100;
            default: sel_c = '0;
        endcase
    end

    assign mapped_c = |sel_c;

    // Only IDLE and RESP present an open address phase; ERR2 drives ready but drops it.
    assign accept_c = hready_q && bus.Hreadyin && bus.Htrans[1] &&
                      ((state == ST_IDLE) || (state == ST_RESP));

    // State register, with the Moore outputs registered alongside it.
    always_ff @(posedge Hclk or negedge Hresetn) begin
        if (!Hresetn) begin
            state    <= ST_IDLE;
            hready_q <= 1'b1;
            hresp_q  <= RESP_OKAY;
            valid_q  <= 1'b0;
        end else begin
            state    <= state_nxt;
            hready_q <= hready_nxt;
            hresp_q  <= hresp_nxt;
            valid_q  <= valid_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE, ST_RESP: begin
                if (accept_c) state_nxt = mapped_c ? ST_CAPT : ST_ERR1;
                else          state_nxt = ST_IDLE;
            end
            ST_CAPT: state_nxt = ST_REQ;
            ST_REQ:  if (bus.req_ack) state_nxt = ST_RESP;
            ST_ERR1: state_nxt = ST_ERR2;
            ST_ERR2: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Output decode of the upcoming state so the registered outputs line up with it.
    always_comb begin
        hready_nxt = 1'b1;
        hresp_nxt  = RESP_OKAY;
        valid_nxt  = 1'b0;
        case (state_nxt)
            ST_CAPT: hready_nxt = 1'b0;
            ST_REQ: begin
                hready_nxt = 1'b0;
                valid_nxt  = 1'b1;
            end
            ST_ERR1: begin
                hready_nxt = 1'b0;
                hresp_nxt  = RESP_ERROR;
            end
            ST_ERR2: hresp_nxt = RESP_ERROR;
            default: begin
                hready_nxt = 1'b1;
                hresp_nxt  = RESP_OKAY;
            end
        endcase
    end

    // Request payload and read data; payload only moves on acceptance or in CAPT.
    always_ff @(posedge Hclk or negedge Hresetn) begin
        if (!Hresetn) begin
            addr_q   <= '0;
            write_q  <= 1'b0;
            sel_q    <= '0;
            wdata_q  <= '0;
            hrdata_q <= '0;
        end else begin
            if (accept_c && mapped_c) begin
                addr_q  <= bus.Haddr;
                write_q <= bus.Hwrite;
                sel_q   <= sel_c;
            end
            if ((state == ST_CAPT) && write_q) begin
                wdata_q <= bus.Hwdata;
            end
            if ((state == ST_REQ) && bus.req_ack && !write_q) begin
                hrdata_q <= bus.ack_rdata;
            end
        end
    end

    // Error counter bumps on the edge that enters ERR1 and sticks at its maximum.
    always_ff @(posedge Hclk or negedge Hresetn) begin
        if (!Hresetn) begin
            err_q <= '0;
        end else if (accept_c && !mapped_c && (err_q != CNT_MAX)) begin
            err_q <= CNT_W'(err_q + CNT_W'(1));
        end
    end

    assign bus.Hreadyout = hready_q;
    assign bus.Hresp     = hresp_q;
    assign bus.Hrdata    = hrdata_q;
    assign bus.req_valid = valid_q;
    assign bus.req_write = write_q;
    assign bus.req_addr  = addr_q;
    assign bus.req_wdata = wdata_q;
    assign bus.req_sel   = sel_q;
    assign bus.err_cnt   = err_q;

endmodule

// File: doc/ahb_slave_if.md
AHB_SLAVE_IF -- requirements
Module: ahb_slave_if

Interface
REQ-001 Hclk  input  1  sole clock; all state SHALL update on rising edge.
REQ-002 Hresetn  input  1  reset, asynchronous assert, active-low.
REQ-003 Hwrite  input  1  1=write, 0=read; sampled in address phase.
REQ-004 Hreadyin  input  1  previous-transfer-complete qualifier from master side.
REQ-005 Htrans  input  2  00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ.
REQ-006 Haddr  input  32  transfer address; sampled in address phase.
REQ-007 Hwdata  input  32  write data; valid in data phase.
REQ-008 Hreadyout  output  1  slave ready; 0 stalls the current data phase.
REQ-009 Hresp  output  2  00 OKAY, 01 ERROR.
REQ-010 Hrdata  output  32  read data, registered.
REQ-011 req_valid  output  1  downstream request strobe.
REQ-012 req_write  output  1  downstream direction.
REQ-013 req_addr  output  32  captured address.
REQ-014 req_wdata  output  32  captured write data.
REQ-015 req_sel  output  3  one-hot peripheral select.
REQ-016 req_ack  input  1  downstream completion, single-cycle pulse.
REQ-017 ack_rdata  input  32  read data, valid with req_ack.
REQ-018 err_cnt  output  8  saturating count of ERROR responses.

Function
REQ-019 Address map: 0x8000_0000-0x83FF_FFFF sel=001; 0x8400_0000-0x87FF_FFFF sel=010; 0x8800_0000-0x8BFF_FFFF sel=100; all else unmapped.
REQ-020 Transfer accepted only when Hreadyout=1, Hreadyin=1 and Htrans[1]=1 (NONSEQ/SEQ); IDLE and BUSY SHALL be ignored with OKAY.
REQ-021 FSM states: IDLE, CAPT, REQ, RESP, ERR1, ERR2.
REQ-022 IDLE: Hreadyout=1, Hresp=OKAY; on accepted mapped transfer latch Haddr, Hwrite, sel -> CAPT; on accepted unmapped -> ERR1; else stay.
REQ-023 CAPT: Hreadyout=0; latch Hwdata into req_wdata when captured write, else hold req_wdata -> REQ.
REQ-024 REQ: req_valid=1, Hreadyout=0; stay until req_ack=1; on req_ack, read latches ack_rdata into Hrdata -> RESP.
REQ-025 req_ack in the first REQ cycle SHALL be honoured; req_ack outside REQ SHALL be ignored.
REQ-026 RESP: Hreadyout=1, Hresp=OKAY; a new transfer accepted here follows IDLE rules (back-to-back pipelining); else -> IDLE.
REQ-027 ERR1: Hreadyout=0, Hresp=01 -> ERR2; ERR2: Hreadyout=1, Hresp=01, address phase present SHALL be ignored -> IDLE.
REQ-028 err_cnt SHALL increment on entry to ERR1, saturate at 255, never wrap.
REQ-029 Minimum latency: address phase cycle 0, data phase completes (Hreadyout=1) in cycle 3 with zero-wait ack.
REQ-030 req_addr, req_write, req_sel, req_wdata SHALL be stable from CAPT through REQ exit.
REQ-031 Hrdata SHALL hold its value except on read ack; write transfers SHALL NOT modify Hrdata.

Reset
REQ-032 Hresetn=0 SHALL immediately force IDLE, Hreadyout=1, Hresp=00, req_valid=0, req_write=0, req_sel=000, req_addr=0, req_wdata=0, Hrdata=0, err_cnt=0, including mid-REQ or mid-ERR.
REQ-033 After release, first acceptance SHALL occur no earlier than the first rising edge with Hresetn=1.

Verification
REQ-034 Write 0x8000_1001, Hwdata 0x8000_0111, ack in 1st REQ cycle -> req_sel=001, req_wdata=0x8000_0111, Hreadyout high cycle 3, Hresp=00.
REQ-035 Read 0x8400_0010, ack after 4 REQ cycles with ack_rdata=0xDEAD_BEEF -> Hreadyout low 5 cycles, Hrdata=0xDEAD_BEEF, sel=010.
REQ-036 Read 0x9000_0000 -> no req_valid, Hresp=01 for 2 cycles (Hreadyout 0 then 1), err_cnt=1.
REQ-037 INCR4 write burst 0x8000_1000 step 4 (NONSEQ+3 SEQ), each accepted in RESP -> four requests, addresses 1000/1004/1008/100C.
REQ-038 Htrans=BUSY/IDLE with Hreadyin=1 -> no state change, Hresp=00.
REQ-039 Hresetn low during REQ -> req_valid=0 same cycle, all outputs at reset values; 256 unmapped accesses -> err_cnt=255.
